// File: rtl/mas_frame_accumulator_pkg.sv
// rtl/mas_frame_accumulator_pkg.sv - shared encodings for the modular frame accumulator
package mas_frame_accumulator_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_HOLD = 2'b10;
   localparam logic [1:0] OP_SUB  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_REDUCE = 2'd2,
      ST_OUT    = 2'd3
   } state_e;

   localparam int TCMP_GE0 = 0;
   localparam int TCMP_GEQ = 1;

endpackage

// File: rtl/mas_reduce_step.sv
// rtl/mas_reduce_step.sv - one compare-then-add/subtract-Q step toward [0, Q)
module mas_reduce_step
   import mas_frame_accumulator_pkg::*;
#(
   parameter int W  = 5,
   parameter int AW = 9
) (
   input  logic [AW-1:0] acc,
   input  logic [W-1:0]  q,
   output logic [AW-1:0] acc_next,
   output logic [1:0]    tcmp,
   output logic          done
);

   logic signed [AW-1:0] acc_s;
   logic signed [AW-1:0] q_ext;

   assign acc_s = acc;
   assign q_ext = {{(AW-W){q[W-1]}}, q};

   // tcmp 10 only arises for a non-positive modulus; the caller never steps that case
   always_comb begin
      tcmp           = 2'b00;
      tcmp[TCMP_GE0] = ~acc[AW-1];
      tcmp[TCMP_GEQ] = (acc_s >= q_ext);
      done           = (tcmp == 2'b01);
      acc_next       = acc;
      if (tcmp == 2'b00) begin
         acc_next = acc + q_ext;
      end else if (tcmp == 2'b11) begin
         acc_next = acc - q_ext;
      end
   end

endmodule

// File: rtl/mas_frame_accumulator.sv
// rtl/mas_frame_accumulator.sv - streams signed operands into a wide accumulator,
// then reduces the frame total into [0, Q) and hands it downstream
module mas_frame_accumulator
   import mas_frame_accumulator_pkg::*;
#(
   parameter int W         = 5,
   parameter int MAX_BEATS = 8,
   parameter int AW        = W + $clog2(MAX_BEATS) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  din,
   input  logic [1:0]    sel,
   input  logic          last,
   input  logic [W-1:0]  q,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-2:0]  dout,
   output logic [AW-1:0] raw_sum,
   output logic [1:0]    tcmp,
   output logic [AW-1:0] iters,
   output logic          err
);

   localparam int CW = $clog2(MAX_BEATS + 1);

   state_e        state_q, state_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [W-1:0]  q_reg_q, q_reg_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          first_q, first_d;
   logic [W-2:0]  dout_q, dout_d;
   logic [AW-1:0] raw_sum_q, raw_sum_d;
   logic [1:0]    tcmp_q, tcmp_d;
   logic [AW-1:0] iters_q, iters_d;
   logic          err_q, err_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;

   logic [AW-1:0] din_ext;
   logic [AW-1:0] base;
   logic [AW-1:0] op_res;
   logic [CW-1:0] cnt_inc;
   logic          beat;
   logic          q_nonpos;
   logic [AW-1:0] step_acc;
   logic [1:0]    step_tcmp;
   logic          step_done;

   mas_reduce_step #(
      .W  (W),
      .AW (AW)
   ) u_step (
      .acc      (acc_q),
      .q        (q_reg_q),
      .acc_next (step_acc),
      .tcmp     (step_tcmp),
      .done     (step_done)
   );

   assign beat     = in_valid & in_ready_q;
   assign q_nonpos = q_reg_q[W-1] | (q_reg_q == '0);
   assign din_ext  = {{(AW-W){din[W-1]}}, din};
   // The first beat of a frame operates on zero rather than on the stale total
   assign base     = (state_q == ST_IDLE) ? '0 : acc_q;
   assign cnt_inc  = (state_q == ST_IDLE) ? CW'(1) : cnt_q + CW'(1);

   always_comb begin
      op_res = base - din_ext;
      case (sel)
         OP_ADD:  op_res = base + din_ext;
         OP_LOAD: op_res = din_ext;
         OP_HOLD: op_res = base;
         default: op_res = base - din_ext;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      q_reg_d   = q_reg_q;
      cnt_d     = cnt_q;
      first_d   = first_q;
      dout_d    = dout_q;
      raw_sum_d = raw_sum_q;
      tcmp_d    = tcmp_q;
      iters_d   = iters_q;
      err_d     = err_q;

      case (state_q)
         ST_IDLE, ST_ACCUM: begin
            if (beat) begin
               acc_d = op_res;
               cnt_d = cnt_inc;
               if (state_q == ST_IDLE) begin
                  q_reg_d = q;
                  err_d   = 1'b0;
               end
               if (last || (cnt_inc == CW'(MAX_BEATS))) begin
                  state_d = ST_REDUCE;
                  first_d = 1'b1;
                  if (!last) begin
                     err_d = 1'b1;
                  end
               end else begin
                  state_d = ST_ACCUM;
               end
            end
         end
         ST_REDUCE: begin
            first_d = 1'b0;
            if (first_q) begin
               raw_sum_d = acc_q;
               tcmp_d    = step_tcmp;
               iters_d   = '0;
            end
            if (first_q && q_nonpos) begin
               err_d   = 1'b1;
               dout_d  = '0;
               state_d = ST_OUT;
            end else if (step_done) begin
               dout_d  = acc_q[W-2:0];
               state_d = ST_OUT;
            end else begin
               acc_d   = step_acc;
               iters_d = (first_q ? '0 : iters_q) + AW'(1);
            end
         end
         default: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
      endcase

      in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_ACCUM);
      out_valid_d = (state_d == ST_OUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         q_reg_q     <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b0;
         dout_q      <= '0;
         raw_sum_q   <= '0;
         tcmp_q      <= '0;
         iters_q     <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         q_reg_q     <= q_reg_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         dout_q      <= dout_d;
         raw_sum_q   <= raw_sum_d;
         tcmp_q      <= tcmp_d;
         iters_q     <= iters_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign raw_sum   = raw_sum_q;
   assign tcmp      = tcmp_q;
   assign iters     = iters_q;
   assign err       = err_q;

endmodule
